// File: rtl/cp0_register_file.sv
// MIPS coprocessor-0 register file: MFC0/MTC0 access, exception/ERET commit, timer and interrupt masking.
// Reads are combinational (pre-write); all updates land on the next clock edge; no backpressure.
module cp0_register_file #(
    parameter int          TLB_NUM             = 16,
    parameter logic [31:0] RESET_VECTOR_EXC    = 32'hBFC00380,
    parameter logic [31:0] RESET_VECTOR_REFILL = 32'hBFC00200
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [7:0]                 read_addr,
    output logic [31:0]                read_data,
    input  logic                       write_enable,
    input  logic [7:0]                 write_addr,
    input  logic [31:0]                write_data,
    input  logic                       exc_valid,
    input  logic [4:0]                 exc_code,
    input  logic [31:0]                exc_pc,
    input  logic                       exc_in_delay_slot,
    input  logic                       exc_badvaddr_valid,
    input  logic [31:0]                exc_badvaddr,
    input  logic                       exc_tlb_refill,
    input  logic                       eret_valid,
    input  logic [5:0]                 hw_interrupt,
    input  logic                       tlbp_valid,
    input  logic                       tlbp_found,
    input  logic [$clog2(TLB_NUM)-1:0] tlbp_index,
    input  logic                       tlbr_valid,
    input  logic [31:0]                tlbr_entry_hi,
    input  logic [31:0]                tlbr_entry_lo0,
    input  logic [31:0]                tlbr_entry_lo1,
    output logic [47:0]                to_if_bus,
    output logic [7:0]                 to_ex_bus,
    output logic                       redirect_valid,
    output logic [$clog2(TLB_NUM)-1:0] tlb_index,
    output logic [31:0]                tlb_entry_hi,
    output logic [31:0]                tlb_entry_lo0,
    output logic [31:0]                tlb_entry_lo1
);

    localparam int IW = $clog2(TLB_NUM);

    localparam logic [7:0] ADDR_INDEX    = {5'd0,  3'd0};
    localparam logic [7:0] ADDR_ENTRYLO0 = {5'd2,  3'd0};
    localparam logic [7:0] ADDR_ENTRYLO1 = {5'd3,  3'd0};
    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_ENTRYHI  = {5'd10, 3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    logic          index_p;
    logic [IW-1:0] index_idx;
    logic [25:0]   entry_lo0;
    logic [25:0]   entry_lo1;
    logic [31:0]   badvaddr;
    logic [31:0]   count;
    logic          count_tick;
    logic [18:0]   entry_hi_vpn2;
    logic [7:0]    entry_hi_asid;
    logic [31:0]   compare;
    logic          status_bev;
    logic [7:0]    status_im;
    logic          status_exl;
    logic          status_ie;
    logic          cause_bd;
    logic          cause_ti;
    logic [5:0]    cause_ip_hw;
    logic [1:0]    cause_ip_sw;
    logic [4:0]    cause_exc_code;
    logic [31:0]   epc;
    logic [31:0]   exception_address;
    logic          redirect_q;

    logic [31:0]   index_word;
    logic [31:0]   entry_hi_word;
    logic [31:0]   status_word;
    logic [31:0]   cause_word;
    logic [7:0]    interrupt_valid;

    logic          wr_index;
    logic          wr_entry_lo0;
    logic          wr_entry_lo1;
    logic          wr_count;
    logic          wr_entry_hi;
    logic          wr_compare;
    logic          wr_status;
    logic          wr_cause;
    logic          wr_epc;
    logic          exc_tlb_code;
    logic          unused_inputs;

    assign index_word    = {index_p, {(31-IW){1'b0}}, index_idx};
    assign entry_hi_word = {entry_hi_vpn2, 5'b0, entry_hi_asid};
    assign status_word   = {9'b0, status_bev, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_word    = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                            1'b0, cause_exc_code, 2'b0};

    assign wr_index     = write_enable && (write_addr == ADDR_INDEX);
    assign wr_entry_lo0 = write_enable && (write_addr == ADDR_ENTRYLO0);
    assign wr_entry_lo1 = write_enable && (write_addr == ADDR_ENTRYLO1);
    assign wr_count     = write_enable && (write_addr == ADDR_COUNT);
    assign wr_entry_hi  = write_enable && (write_addr == ADDR_ENTRYHI);
    assign wr_compare   = write_enable && (write_addr == ADDR_COMPARE);
    assign wr_status    = write_enable && (write_addr == ADDR_STATUS);
    assign wr_cause     = write_enable && (write_addr == ADDR_CAUSE);
    assign wr_epc       = write_enable && (write_addr == ADDR_EPC);

    // TLB modified/load/store exceptions capture the faulting VPN2 into EntryHi.
    assign exc_tlb_code = (exc_code == 5'd1) || (exc_code == 5'd2) || (exc_code == 5'd3);

    assign interrupt_valid = {cause_ip_hw, cause_ip_sw} & status_im
                           & {8{status_ie & ~status_exl}};

    assign unused_inputs = ^{tlbr_entry_hi[12:8], tlbr_entry_lo0[31:26], tlbr_entry_lo1[31:26]};

    always_comb begin
        read_data = 32'd0;
        case (read_addr)
            ADDR_INDEX:    read_data = index_word;
            ADDR_ENTRYLO0: read_data = {6'b0, entry_lo0};
            ADDR_ENTRYLO1: read_data = {6'b0, entry_lo1};
            ADDR_BADVADDR: read_data = badvaddr;
            ADDR_COUNT:    read_data = count;
            ADDR_ENTRYHI:  read_data = entry_hi_word;
            ADDR_COMPARE:  read_data = compare;
            ADDR_STATUS:   read_data = status_word;
            ADDR_CAUSE:    read_data = cause_word;
            ADDR_EPC:      read_data = epc;
            default:       read_data = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_tick <= 1'b0;
            count      <= 32'd0;
        end else begin
            count_tick <= ~count_tick;
            if (wr_count) begin
                count <= write_data;
            end else if (count_tick) begin
                count <= count + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            compare <= 32'd0;
        end else if (wr_compare) begin
            compare <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            status_bev <= 1'b1;
            status_im  <= 8'd0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (exc_valid) begin
            status_exl <= 1'b1;
        end else if (eret_valid) begin
            status_exl <= 1'b0;
        end else if (wr_status) begin
            status_im  <= write_data[15:8];
            status_exl <= write_data[1];
            status_ie  <= write_data[0];
        end
    end

    // Software IP bits are the only MTC0-writable Cause field; an exception claims the whole register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cause_bd       <= 1'b0;
            cause_ti       <= 1'b0;
            cause_ip_hw    <= 6'd0;
            cause_ip_sw    <= 2'd0;
            cause_exc_code <= 5'd0;
        end else begin
            cause_ip_hw <= {hw_interrupt[5] | cause_ti, hw_interrupt[4:0]};
            if (wr_compare) begin
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end
            if (exc_valid) begin
                cause_exc_code <= exc_code;
                if (!status_exl) begin
                    cause_bd <= exc_in_delay_slot;
                end
            end else if (wr_cause) begin
                cause_ip_sw <= write_data[9:8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            epc <= 32'd0;
        end else if (exc_valid && !status_exl) begin
            epc <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
        end else if (wr_epc) begin
            epc <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            badvaddr <= 32'd0;
        end else if (exc_valid && exc_badvaddr_valid) begin
            badvaddr <= exc_badvaddr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            entry_hi_vpn2 <= 19'd0;
            entry_hi_asid <= 8'd0;
        end else if (exc_valid && exc_tlb_code) begin
            entry_hi_vpn2 <= exc_badvaddr[31:13];
        end else if (wr_entry_hi) begin
            entry_hi_vpn2 <= write_data[31:13];
            entry_hi_asid <= write_data[7:0];
        end else if (tlbr_valid) begin
            entry_hi_vpn2 <= tlbr_entry_hi[31:13];
            entry_hi_asid <= tlbr_entry_hi[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            entry_lo0 <= 26'd0;
            entry_lo1 <= 26'd0;
        end else begin
            if (wr_entry_lo0) begin
                entry_lo0 <= write_data[25:0];
            end else if (tlbr_valid) begin
                entry_lo0 <= tlbr_entry_lo0[25:0];
            end
            if (wr_entry_lo1) begin
                entry_lo1 <= write_data[25:0];
            end else if (tlbr_valid) begin
                entry_lo1 <= tlbr_entry_lo1[25:0];
            end
        end
    end

    // An MTC0 to Index also suppresses the TLBP probe-bit update in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            index_p   <= 1'b0;
            index_idx <= '0;
        end else if (wr_index) begin
            index_idx <= write_data[IW-1:0];
        end else if (tlbp_valid) begin
            index_p <= ~tlbp_found;
            if (tlbp_found) begin
                index_idx <= tlbp_index;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            redirect_q        <= 1'b0;
            exception_address <= 32'd0;
        end else begin
            redirect_q <= exc_valid | eret_valid;
            if (exc_valid) begin
                exception_address <= (exc_tlb_refill && !status_exl) ? RESET_VECTOR_REFILL
                                                                     : RESET_VECTOR_EXC;
            end else if (eret_valid) begin
                exception_address <= epc;
            end
        end
    end

    assign redirect_valid = redirect_q;
    assign to_if_bus      = {exception_address, interrupt_valid, entry_hi_asid};
    assign to_ex_bus      = entry_hi_asid;
    assign tlb_index      = index_idx;
    assign tlb_entry_hi   = entry_hi_word;
    assign tlb_entry_lo0  = {6'b0, entry_lo0};
    assign tlb_entry_lo1  = {6'b0, entry_lo1};

endmodule

// File: doc/cp0_register_file.md
Name: cp0_register_file

Overview:
- Coprocessor-0 register file of the MIPS core.
- Holds Index, EntryLo0/1, BadVAddr, Count, EntryHi, Compare, Status, Cause and EPC.
- Serves MFC0/MTC0 from the execute/writeback path and absorbs exception and ERET commits from writeback.
- Produces the cp0-to-IF bus (redirect address, masked interrupt vector, ASID), the cp0-to-EX ASID, and TLB-write operands.

Parameters:
TLB_NUM, 16, TLB entry count; index field width = clog2(TLB_NUM)
RESET_VECTOR_EXC, 32'hBFC00380, general exception vector (BEV=1)
RESET_VECTOR_REFILL, 32'hBFC00200, TLB refill vector (BEV=1, EXL=0)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
read_addr  in  8  {rd[4:0], sel[2:0]} for MFC0
read_data  out  32  combinational register read, pre-write value
write_enable  in  1  MTC0 commit
write_addr  in  8  {rd, sel} for MTC0
write_data  in  32  MTC0 data
exc_valid  in  1  exception commits this cycle
exc_code  in  5  Cause.ExcCode value
exc_pc  in  32  PC of faulting instruction
exc_in_delay_slot  in  1  faulting instruction is in a delay slot
exc_badvaddr_valid  in  1  update BadVAddr
exc_badvaddr  in  32  faulting address
exc_tlb_refill  in  1  TLB miss (refill vector)
eret_valid  in  1  ERET commits
hw_interrupt  in  6  external interrupt lines, level
tlbp_valid  in  1  TLBP result write
tlbp_found  in  1  probe hit
tlbp_index  in  clog2(TLB_NUM)  hit index
tlbr_valid  in  1  TLBR result write
tlbr_entry_hi  in  32  read entry (EntryHi layout)
tlbr_entry_lo0  in  32  read entry (EntryLo layout)
tlbr_entry_lo1  in  32  read entry (EntryLo layout)
to_if_bus  out  48  {exception_address, interrupt_valid[7:0], asid[7:0]}
to_ex_bus  out  8  {asid}
redirect_valid  out  1  registered; exception or ERET redirect pending to IF
tlb_index  out  clog2(TLB_NUM)  Index.index, for TLBWI
tlb_entry_hi  out  32  EntryHi
tlb_entry_lo0  out  32  EntryLo0
tlb_entry_lo1  out  32  EntryLo1

Behaviour:
- Register map, sel 0 only: Index 0, EntryLo0 2, EntryLo1 3, BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14. Other addresses read 0; writes to them are ignored.
- Reset state:
  - Status: BEV=1, all other fields 0.
  - Cause, Count, Compare, EPC, BadVAddr, EntryHi, EntryLo0/1, Index: 0.
  - Count tick toggle: 0.
  - redirect_valid: 0; exception_address: 0.
- MTC0 write masks (unlisted bits hold):
  - Index.index only.
  - EntryLo bits [25:0].
  - EntryHi VPN2 [31:13] and ASID [7:0].
  - Status IM [15:8], EXL [1], IE [0].
  - Cause IP[1:0] only.
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr: read-only.
  - Writes take effect next cycle.
- Count increments by 1 every second cycle via an internal toggle. Wraps 32'hFFFFFFFF -> 0. An MTC0 to Count overrides the increment that cycle.
- Timer interrupt:
  - Cause.TI sets when Count == Compare (registered compare).
  - An MTC0 to Compare clears TI; the write wins over a set in the same cycle.
- Cause.IP[7:2] = {hw_interrupt[5] | TI, hw_interrupt[4:0]}, sampled every cycle.
- interrupt_valid = {IP[7:2], IP[1:0]} & IM & {8{IE & ~EXL}}.
- Exception commit (exc_valid):
  - If EXL=0: EPC <= exc_in_delay_slot ? exc_pc-4 : exc_pc; Cause.BD <= exc_in_delay_slot.
  - If EXL=1: EPC and BD hold.
  - Always: EXL <= 1; ExcCode <= exc_code.
  - If exc_badvaddr_valid: BadVAddr <= exc_badvaddr.
  - For ExcCode 1/2/3: EntryHi.VPN2 <= exc_badvaddr[31:13].
  - exception_address <= (exc_tlb_refill & ~EXL) ? RESET_VECTOR_REFILL : RESET_VECTOR_EXC.
  - redirect_valid pulses 1 for one cycle.
- ERET commit: EXL <= 0; exception_address <= EPC; redirect_valid pulses 1.
- Same-cycle priority: exception > ERET > MTC0 > TLBP/TLBR. The losing writes to an overlapping register are dropped; non-overlapping writes all apply.
- TLBP: Index.P <= ~tlbp_found; Index.index <= tlbp_index when found, else holds.
- TLBR: EntryHi, EntryLo0 and EntryLo1 load from the tlbr inputs, with the same masks as MTC0.
- ASID outputs track EntryHi.ASID with 1-cycle latency after any write.
- Reset asserted mid-operation restores the reset state on the next edge and cancels any pending redirect.

Test Plan:
- Reset, then MFC0 Status -> 32'h00400000; Cause -> 0; redirect_valid=0.
- MTC0 Compare=5, Count=0; wait 10 cycles -> Cause.TI=1. MTC0 Compare -> TI=0 next cycle.
- Status IE=1, IM[7]=1, EXL=0, TI pending -> interrupt_valid=8'h80. Set EXL=1 -> 8'h00.
- exc_valid, exc_code=4, exc_pc=32'hBFC00010, delay slot=1, badvaddr=32'h00000003:
  - EPC=32'hBFC0000C, BD=1, EXL=1, ExcCode=4, BadVAddr=3.
  - exception_address=32'hBFC00380, redirect_valid pulses once.
- Nested exception with EXL=1 -> EPC unchanged. ERET -> EXL=0, exception_address=EPC.
- TLB refill with EXL=0, badvaddr=32'h12345678 -> EntryHi.VPN2=19'h091A2, vector 32'hBFC00200. TLBP miss -> Index.P=1.
